// File: rtl/trigger_multiport.sv
// Launch sequencer for one HLS actor: decodes return codes, sleeps on port masks and debounces
// network_idle before completing. Define TRIGGER_STATS_EN to build fire_count/sleep_cycles.
module trigger_multiport #(
    parameter int unsigned NUM_INPUTS    = 4,
    parameter int unsigned NUM_OUTPUTS   = 4,
    parameter int unsigned MODE          = 0,
    parameter int unsigned IDLE_DEBOUNCE = 4,
    parameter int unsigned CNT_W         = 32
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic                   ap_start,
    output logic                   ap_done,
    output logic                   ap_ready,
    output logic                   ap_idle,
    input  logic                   network_idle,
    input  logic [NUM_INPUTS-1:0]  has_tokens,
    input  logic [NUM_OUTPUTS-1:0] has_space,
    input  logic [1:0]             actor_return,
    input  logic [NUM_INPUTS-1:0]  actor_in_mask,
    input  logic [NUM_OUTPUTS-1:0] actor_out_mask,
    input  logic                   actor_done,
    input  logic                   actor_idle,
    input  logic                   actor_launch_predicate,
    output logic                   actor_start,
    output logic                   sleeping,
    output logic [CNT_W-1:0]       fire_count,
    output logic [CNT_W-1:0]       sleep_cycles
);

    typedef enum logic [2:0] {
        StStandBy,
        StTryLaunch,
        StLaunch,
        StCheckReturn,
        StProbeIn,
        StProbeOut
    } state_e;

    localparam logic [1:0] RetNoFire     = 2'd0;
    localparam logic [1:0] RetExecuted   = 2'd1;
    localparam logic [1:0] RetWaitInput  = 2'd2;
    localparam logic [1:0] RetWaitOutput = 2'd3;
    localparam int unsigned IdleW = $clog2(IDLE_DEBOUNCE + 1);

    state_e                 state_q, state_d, relaunch;
    logic [NUM_INPUTS-1:0]  in_mask_q, in_mask_d;
    logic [NUM_OUTPUTS-1:0] out_mask_q, out_mask_d;
    logic                   nofire_q, nofire_d;
    logic [IdleW-1:0]       idle_cnt_q, idle_cnt_d;
    logic                   ap_done_q;
    logic                   can_launch, counting, idle_ok, do_decode, nofire_hit;

    if (MODE == 1) begin : g_relaunch_try
        assign relaunch = StTryLaunch;
    end else begin : g_relaunch_direct
        assign relaunch = StLaunch;
    end

    assign can_launch = actor_idle & ~ap_start & (actor_launch_predicate | (MODE != 1));
    assign counting   = (state_q == StCheckReturn) || (state_q == StProbeIn) ||
                        (state_q == StProbeOut);
    // Counter holds completed idle cycles; this cycle's network_idle completes the streak.
    assign idle_ok    = network_idle && (idle_cnt_q >= IdleW'(IDLE_DEBOUNCE - 1));

    always_comb begin
        state_d    = state_q;
        in_mask_d  = in_mask_q;
        out_mask_d = out_mask_q;
        do_decode  = 1'b0;
        nofire_hit = 1'b0;
        unique case (state_q)
            StStandBy:   if (ap_start) state_d = StTryLaunch;
            StTryLaunch: if (can_launch) state_d = StLaunch;
            StLaunch: begin
                if (actor_done) do_decode = 1'b1;
                else            state_d = StCheckReturn;
            end
            StCheckReturn: begin
                if (actor_done && (!nofire_q || actor_return != RetNoFire)) begin
                    do_decode = 1'b1;
                end else if (nofire_q) begin
                    if (!network_idle) state_d = relaunch;
                    else if (idle_ok)  state_d = StStandBy;
                end
            end
            StProbeIn: begin
                if (|(has_tokens & in_mask_q)) state_d = StLaunch;
                else if (idle_ok)              state_d = StStandBy;
            end
            StProbeOut: begin
                if (|(has_space & out_mask_q)) state_d = StLaunch;
                else if (idle_ok)              state_d = StStandBy;
            end
            default: state_d = StStandBy;
        endcase

        if (do_decode) begin
            unique case (actor_return)
                RetExecuted: state_d = relaunch;
                RetWaitInput: begin
                    in_mask_d = (actor_in_mask == '0) ? '1 : actor_in_mask;
                    state_d   = StProbeIn;
                end
                RetWaitOutput: begin
                    out_mask_d = (actor_out_mask == '0) ? '1 : actor_out_mask;
                    state_d    = StProbeOut;
                end
                RetNoFire: begin
                    state_d    = StCheckReturn;
                    nofire_hit = 1'b1;
                end
            endcase
        end
    end

    // nofire marks the post-NO_FIRE hold phase of CHECK_RETURN.
    assign nofire_d = (state_d == StCheckReturn) && (nofire_hit || nofire_q);

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        // Entering the hold phase restarts the debounce window.
        if ((state_d != state_q) || !network_idle || (nofire_d && !nofire_q)) begin
            idle_cnt_d = '0;
        end else if (counting && (idle_cnt_q != IdleW'(IDLE_DEBOUNCE))) begin
            idle_cnt_d = idle_cnt_q + IdleW'(1);
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q    <= StStandBy;
            in_mask_q  <= '0;
            out_mask_q <= '0;
            nofire_q   <= 1'b0;
            idle_cnt_q <= '0;
            ap_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_mask_q  <= in_mask_d;
            out_mask_q <= out_mask_d;
            nofire_q   <= nofire_d;
            idle_cnt_q <= idle_cnt_d;
            ap_done_q  <= (state_d == StStandBy) && (state_q != StStandBy);
        end
    end

    assign ap_done     = ap_done_q;
    assign ap_ready    = ap_done_q;
    assign ap_idle     = (state_q == StStandBy);
    assign actor_start = (state_q == StLaunch);
    assign sleeping    = (state_q == StProbeIn) || (state_q == StProbeOut);

`ifdef TRIGGER_STATS_EN
    logic [CNT_W-1:0] fire_q, sleep_q;
    logic             exec_hit;

    assign exec_hit = do_decode && (actor_return == RetExecuted);

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            fire_q  <= '0;
            sleep_q <= '0;
        end else begin
            if (exec_hit && (fire_q != '1))  fire_q  <= fire_q + CNT_W'(1);
            if (sleeping && (sleep_q != '1)) sleep_q <= sleep_q + CNT_W'(1);
        end
    end

    assign fire_count   = fire_q;
    assign sleep_cycles = sleep_q;
`else
    assign fire_count   = '0;
    assign sleep_cycles = '0;
`endif

endmodule

// File: tb/tb_trigger_multiport.sv
// Directed bench for trigger_multiport: a MODE=0 and a MODE=1 instance checked every cycle
// against a phase-level model, plus hand-computed literal expectations.
module tb_trigger_multiport;

    localparam int D = 4;
    localparam int PhIdle = 0, PhTry = 1, PhLaunch = 2, PhWait = 3, PhHold = 4,
                   PhSleepIn = 5, PhSleepOut = 6;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start0, ap_start1;
    logic        network_idle, actor_done, actor_idle, actor_launch_predicate;
    logic [3:0]  has_tokens, has_space, actor_in_mask, actor_out_mask;
    logic [1:0]  actor_return;
    logic        ap_done0, ap_ready0, ap_idle0, actor_start0, sleeping0;
    logic        ap_done1, ap_ready1, ap_idle1, actor_start1, sleeping1;
    logic [31:0] fire_count0, sleep_cycles0, fire_count1, sleep_cycles1;

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 1'b0;
    int starts0 = 0;

    int         m_ph[2], m_run[2], m_fire[2], m_sleep[2];
    logic [3:0] m_inm[2], m_outm[2];
    bit         m_done[2];

    always #5 ap_clk = ~ap_clk;

    trigger_multiport #(.NUM_INPUTS(4), .NUM_OUTPUTS(4), .MODE(0), .IDLE_DEBOUNCE(D),
                        .CNT_W(32)) u_dut0 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start0), .ap_done(ap_done0),
        .ap_ready(ap_ready0), .ap_idle(ap_idle0), .network_idle(network_idle),
        .has_tokens(has_tokens), .has_space(has_space), .actor_return(actor_return),
        .actor_in_mask(actor_in_mask), .actor_out_mask(actor_out_mask),
        .actor_done(actor_done), .actor_idle(actor_idle),
        .actor_launch_predicate(actor_launch_predicate), .actor_start(actor_start0),
        .sleeping(sleeping0), .fire_count(fire_count0), .sleep_cycles(sleep_cycles0)
    );

    trigger_multiport #(.NUM_INPUTS(4), .NUM_OUTPUTS(4), .MODE(1), .IDLE_DEBOUNCE(D),
                        .CNT_W(32)) u_dut1 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start1), .ap_done(ap_done1),
        .ap_ready(ap_ready1), .ap_idle(ap_idle1), .network_idle(network_idle),
        .has_tokens(has_tokens), .has_space(has_space), .actor_return(actor_return),
        .actor_in_mask(actor_in_mask), .actor_out_mask(actor_out_mask),
        .actor_done(actor_done), .actor_idle(actor_idle),
        .actor_launch_predicate(actor_launch_predicate), .actor_start(actor_start1),
        .sleeping(sleeping1), .fire_count(fire_count1), .sleep_cycles(sleep_cycles1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int stat(input int v);
        stat = v;
`ifndef TRIGGER_STATS_EN
        stat = 0;
`endif
    endfunction

    // Model: phase per instance, streak of consecutive idle cycles inside the current phase.
    task automatic model_reset(input int k);
        m_ph[k] = PhIdle; m_run[k] = 0; m_fire[k] = 0; m_sleep[k] = 0;
        m_inm[k] = '0; m_outm[k] = '0; m_done[k] = 1'b0;
    endtask

    task automatic model_step(input int k);
        int p, np, relaunch, streak;
        bit dec, start;
        p        = m_ph[k];
        np       = p;
        dec      = 1'b0;
        start    = (k == 0) ? ap_start0 : ap_start1;
        relaunch = (k == 1) ? PhTry : PhLaunch;
        streak   = network_idle ? m_run[k] + 1 : 0;
        case (p)
            PhIdle:     if (start) np = PhTry;
            PhTry:      if (actor_idle && !start && (k == 0 || actor_launch_predicate))
                            np = PhLaunch;
            PhLaunch:   if (actor_done) dec = 1'b1; else np = PhWait;
            PhWait:     if (actor_done) dec = 1'b1;
            PhHold: begin
                if (actor_done && actor_return != 2'd0) dec = 1'b1;
                else if (!network_idle) np = relaunch;
                else if (streak >= D) np = PhIdle;
            end
            PhSleepIn: begin
                if ((has_tokens & m_inm[k]) != 0) np = PhLaunch;
                else if (streak >= D) np = PhIdle;
            end
            PhSleepOut: begin
                if ((has_space & m_outm[k]) != 0) np = PhLaunch;
                else if (streak >= D) np = PhIdle;
            end
            default: np = PhIdle;
        endcase
        if (dec) begin
            case (actor_return)
                2'd0: np = PhHold;
                2'd1: begin np = relaunch; m_fire[k]++; end
                2'd2: begin
                    m_inm[k] = (actor_in_mask == 0) ? 4'hf : actor_in_mask;
                    np = PhSleepIn;
                end
                default: begin
                    m_outm[k] = (actor_out_mask == 0) ? 4'hf : actor_out_mask;
                    np = PhSleepOut;
                end
            endcase
        end
        if (p == PhSleepIn || p == PhSleepOut) m_sleep[k]++;
        m_done[k] = (np == PhIdle) && (p != PhIdle);
        m_run[k]  = (np != p) ? 0 : ((p >= PhWait) ? streak : 0);
        m_ph[k]   = np;
    endtask

    always @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            model_reset(0); model_reset(1);
        end else begin
            model_step(0); model_step(1);
        end
    end

    task automatic cmp_dut(input int k);
        string s;
        s = $sformatf("dut%0d", k);
        check({s, ".ap_idle"}, (k == 0) ? ap_idle0 : ap_idle1, m_ph[k] == PhIdle);
        check({s, ".actor_start"}, (k == 0) ? actor_start0 : actor_start1,
              m_ph[k] == PhLaunch);
        check({s, ".sleeping"}, (k == 0) ? sleeping0 : sleeping1,
              m_ph[k] == PhSleepIn || m_ph[k] == PhSleepOut);
        check({s, ".ap_done"}, (k == 0) ? ap_done0 : ap_done1, m_done[k]);
        check({s, ".ap_ready"}, (k == 0) ? ap_ready0 : ap_ready1, m_done[k]);
        check({s, ".fire_count"}, (k == 0) ? fire_count0 : fire_count1, stat(m_fire[k]));
        check({s, ".sleep_cycles"}, (k == 0) ? sleep_cycles0 : sleep_cycles1,
              stat(m_sleep[k]));
    endtask

    always @(negedge ap_clk) begin
        if (cmp_en) begin
            cmp_dut(0);
            cmp_dut(1);
        end
        if (actor_start0) starts0++;
    end

    task automatic do_reset();
        @(negedge ap_clk);
        #1 ap_rst = 1'b1;
        #2 ap_rst = 1'b0;
        @(negedge ap_clk);
    endtask

    task automatic start_pulse(input int k);
        if (k == 0) ap_start0 = 1'b1; else ap_start1 = 1'b1;
        @(negedge ap_clk);
        ap_start0 = 1'b0;
        ap_start1 = 1'b0;
    endtask

    task automatic wait_launch(input int k);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if ((k == 0) ? actor_start0 : actor_start1) begin
                ok = 1'b1;
                break;
            end
            @(negedge ap_clk);
        end
        check($sformatf("wait_launch%0d", k), ok, 1);
    endtask

    task automatic give_return(input logic [1:0] ret, input logic [3:0] im,
                               input logic [3:0] om, input int delay);
        repeat (delay) @(negedge ap_clk);
        actor_return   = ret;
        actor_in_mask  = im;
        actor_out_mask = om;
        actor_done     = 1'b1;
        @(negedge ap_clk);
        actor_done     = 1'b0;
    endtask

    task automatic wait_done(input int k, output int n);
        n = 0;
        while (!((k == 0) ? ap_done0 : ap_done1) && n < 40) begin
            @(negedge ap_clk);
            n++;
        end
        check($sformatf("wait_done%0d", k), (k == 0) ? ap_done0 : ap_done1, 1);
    endtask

    task automatic finish_run(input int k);
        int n;
        network_idle = 1'b1;
        give_return(2'd0, 4'h0, 4'h0, 0);
        wait_done(k, n);
        network_idle = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n, pulses;
        int pat[7];
        pat = '{1, 1, 0, 1, 1, 1, 1};
        ap_rst = 1'b1; ap_start0 = 1'b0; ap_start1 = 1'b0;
        network_idle = 1'b0; actor_done = 1'b0; actor_idle = 1'b1;
        actor_launch_predicate = 1'b0; has_tokens = '0; has_space = '0;
        actor_in_mask = '0; actor_out_mask = '0; actor_return = 2'd0;
        repeat (3) @(negedge ap_clk);
        ap_rst = 1'b0;
        cmp_en = 1'b1;
        @(negedge ap_clk);
        check("rst.ap_idle", ap_idle0, 1);
        check("rst.actor_start", actor_start0, 0);
        check("rst.ap_done", ap_done0, 0);
        check("rst.sleeping", sleeping1, 0);

        // Reset while in LAUNCH: back to STAND_BY at once, no completion pulse.
        start_pulse(0);
        wait_launch(0);
        #1 ap_rst = 1'b1;
        #1 check("mid_rst.ap_idle", ap_idle0, 1);
        check("mid_rst.actor_start", actor_start0, 0);
        #1 ap_rst = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(negedge ap_clk);
            if (ap_done0) pulses++;
        end
        check("mid_rst.no_done", pulses, 0);

        // EXECUTED, EXECUTED (after a 2-cycle wait), then NO_FIRE with the network idle.
        starts0 = 0;
        start_pulse(0);
        wait_launch(0);
        give_return(2'd1, 4'h0, 4'h0, 0);
        wait_launch(0);
        give_return(2'd1, 4'h0, 4'h0, 2);
        wait_launch(0);
        network_idle = 1'b1;
        give_return(2'd0, 4'h0, 4'h0, 0);
        wait_done(0, n);
        check("run.done_latency", n, 4);
        check("run.launch_cycles", starts0, 3);
        check("run.fire_count", fire_count0, stat(2));
        network_idle = 1'b0;
        @(negedge ap_clk);
        check("run.done_one_cycle", ap_done0, 0);

        // WAIT_INPUT on port 2 only.
        start_pulse(0);
        wait_launch(0);
        has_tokens = 4'b0011;
        give_return(2'd2, 4'b0100, 4'h0, 0);
        check("probe_in.asleep", sleeping0, 1);
        @(negedge ap_clk);
        check("probe_in.masked_off", actor_start0, 0);
        has_tokens = 4'b0100;
        @(negedge ap_clk);
        check("probe_in.wake", actor_start0, 1);
        has_tokens = 4'b0000;
        finish_run(0);

        // WAIT_OUTPUT with an all-zero mask wakes on any space; five sleeping cycles.
        do_reset();
        start_pulse(0);
        wait_launch(0);
        give_return(2'd3, 4'h0, 4'h0, 0);
        repeat (4) @(negedge ap_clk);
        check("probe_out.asleep", sleeping0, 1);
        has_space = 4'b1000;
        @(negedge ap_clk);
        check("probe_out.wake", actor_start0, 1);
        check("probe_out.sleep_cycles", sleep_cycles0, stat(5));
        has_space = 4'b0000;
        finish_run(0);

        // Debounce inside PROBE_IN with network_idle 1,1,0,1,1,1,1.
        start_pulse(0);
        wait_launch(0);
        give_return(2'd2, 4'b0001, 4'h0, 0);
        for (int i = 0; i < 7; i++) begin
            network_idle = pat[i][0];
            check($sformatf("debounce.asleep%0d", i), sleeping0, 1);
            @(negedge ap_clk);
        end
        check("debounce.stand_by", ap_idle0, 1);
        check("debounce.done", ap_done0, 1);
        network_idle = 1'b0;

        // MODE=1: launch held off by the predicate; relaunch goes through TRY_LAUNCH.
        start_pulse(1);
        for (int i = 0; i < 3; i++) begin
            check("mode1.held", actor_start1, 0);
            check("mode1.busy", ap_idle1, 0);
            @(negedge ap_clk);
        end
        check("mode1.still_held", actor_start1, 0);
        actor_launch_predicate = 1'b1;
        @(negedge ap_clk);
        check("mode1.launch", actor_start1, 1);
        give_return(2'd1, 4'h0, 4'h0, 0);
        check("mode1.relaunch_via_try", actor_start1, 0);
        @(negedge ap_clk);
        check("mode1.relaunch", actor_start1, 1);
        actor_launch_predicate = 1'b0;
        finish_run(1);

        repeat (3) @(negedge ap_clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/trigger_multiport.md
Name: trigger_multiport

Overview:
- Parametrised successor to the single-port actor trigger.
- Sequences launches of one HLS actor and decodes a 2-bit return code: executed, no-fire, wait-input or wait-output.
- Sleeps on a per-port wait mask until a masked port can make progress.
- Debounces network_idle before declaring completion; sits between the network controller and each actor instance.

Parameters:
- NUM_INPUTS, 4, number of input FIFO ports (1..32)
- NUM_OUTPUTS, 4, number of output FIFO ports (1..32)
- MODE, 0, 0=actor trigger (relaunch directly), 1=input/output trigger (relaunch via TRY_LAUNCH, gated by actor_launch_predicate)
- IDLE_DEBOUNCE, 4, consecutive network_idle cycles required before returning to STAND_BY (>=1)
- CNT_W, 32, width of statistics counters

Ports:
- ap_clk  in  1  clock
- ap_rst  in  1  reset, asynchronous, active-high
- ap_start  in  1  run request from network controller
- ap_done  out  1  one-cycle completion pulse
- ap_ready  out  1  equals ap_done
- ap_idle  out  1  high in STAND_BY
- network_idle  in  1  all actors in network idle
- has_tokens  in  NUM_INPUTS  per-input non-empty
- has_space  in  NUM_OUTPUTS  per-output not-full
- actor_return  in  2  0=NO_FIRE, 1=EXECUTED, 2=WAIT_INPUT, 3=WAIT_OUTPUT; valid with actor_done
- actor_in_mask  in  NUM_INPUTS  inputs actor blocked on; valid with actor_done
- actor_out_mask  in  NUM_OUTPUTS  outputs actor blocked on; valid with actor_done
- actor_done  in  1  actor finished call
- actor_idle  in  1  actor idle
- actor_launch_predicate  in  1  launch permitted (MODE=1 only)
- actor_start  out  1  actor start
- sleeping  out  1  high in PROBE_IN or PROBE_OUT
- fire_count  out  CNT_W  EXECUTED returns (stats)
- sleep_cycles  out  CNT_W  cycles spent sleeping (stats)

Behaviour:
- Reset (async, asserted): state=STAND_BY, masks=0, debounce counter=0, ap_done=0, ap_ready=0, ap_idle=1, actor_start=0, sleeping=0, counters=0.
- Outputs: actor_start = (state==LAUNCH); ap_idle = (state==STAND_BY); sleeping = (state in PROBE_IN/PROBE_OUT). All decode the registered state.
- ap_done: registered; high exactly one cycle, the first STAND_BY cycle after a run. Never high after reset alone.
- can_launch: actor_idle & ~ap_start, additionally & actor_launch_predicate when MODE=1.
- RELAUNCH = LAUNCH if MODE=0, else TRY_LAUNCH.
- idle_ok: debounce counter reached IDLE_DEBOUNCE.
  - Counter increments (saturating) each cycle network_idle=1 while in CHECK_RETURN, PROBE_IN or PROBE_OUT.
  - Clears on network_idle=0 and on every state change.
- Return decode, applied when actor_done=1 in LAUNCH or CHECK_RETURN:
  - EXECUTED -> RELAUNCH.
  - WAIT_INPUT -> latch actor_in_mask, go PROBE_IN. An all-zero mask is treated as all-ones.
  - WAIT_OUTPUT -> latch actor_out_mask, go PROBE_OUT. An all-zero mask is treated as all-ones.
  - NO_FIRE -> CHECK_RETURN holding for debounce.
- FSM transitions:
  - STAND_BY: ap_start -> TRY_LAUNCH.
  - TRY_LAUNCH: can_launch -> LAUNCH.
  - LAUNCH: actor_done=0 -> CHECK_RETURN; actor_done=1 -> return decode.
  - CHECK_RETURN:
    - actor_done=1 with EXECUTED, WAIT_INPUT or WAIT_OUTPUT -> return decode.
    - After a NO_FIRE return: network_idle=0 -> RELAUNCH; idle_ok -> STAND_BY; otherwise hold.
  - PROBE_IN: |(has_tokens & in_mask) -> LAUNCH; else idle_ok -> STAND_BY; else hold.
  - PROBE_OUT: |(has_space & out_mask) -> LAUNCH; else idle_ok -> STAND_BY; else hold.
- Simultaneous events: in probe states, wake has priority over idle_ok in the same cycle.
- ap_start during a run: ignored.
- Reset mid-run: immediate return to STAND_BY; no ap_done pulse.
- Counters: saturate at all-ones, no wrap.

Optional Feature:
- Macro: TRIGGER_STATS_EN
- Defined: fire_count increments on each EXECUTED decode; sleep_cycles increments each cycle sleeping=1. Both clear only on reset.
- Undefined: no counter registers are built; fire_count and sleep_cycles are tied to 0.

Test Plan:
- Reset while in LAUNCH -> next cycle ap_idle=1, actor_start=0, ap_done never pulses.
- MODE=0, ap_start, actor returns EXECUTED twice then NO_FIRE with network_idle=1, IDLE_DEBOUNCE=4:
  - actor_start high in 3 LAUNCH cycles.
  - ap_done pulses one cycle, 4 cycles after the NO_FIRE return.
  - fire_count=2.
- WAIT_INPUT, in_mask=4'b0100: has_tokens=4'b0011 stays asleep; has_tokens=4'b0100 -> LAUNCH the next cycle.
- WAIT_OUTPUT, out_mask=0, has_space=4'b1000 after 5 cycles -> wakes (all-ones mask); sleep_cycles=5.
- PROBE_IN, network_idle toggling 1,1,0,1,1,1,1 -> STAND_BY only after the final 4 consecutive idle cycles.
- MODE=1, actor_launch_predicate=0 for 3 cycles -> remains in TRY_LAUNCH; launches on the cycle predicate=1.
